// File: rtl/stage_memory_pkg.sv
// Shared CPU types for the memory stage: access mode/size enums, the
// pipeline control word, and store formatting / alignment helpers.
package stage_memory_pkg;

    typedef enum logic [1:0] {
        MA_NONE  = 2'd0,
        MA_LOAD  = 2'd1,
        MA_STORE = 2'd2
    } ma_mode_t;

    typedef enum logic [1:0] {
        MA_BYTE = 2'd0,
        MA_HALF = 2'd1,
        MA_WORD = 2'd2
    } ma_size_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb_en;
        ma_mode_t   ma_mode;
        ma_size_t   ma_size;
        logic       ma_signed;
    } control_word_t;

    // Byte enables for an access of the given size at byte offset a.
    function automatic logic [3:0] store_mask(input ma_size_t size, input logic [1:0] a);
        case (size)
            MA_BYTE: return 4'b0001 << a;
            MA_HALF: return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the mask alone selects bytes.
    function automatic logic [31:0] store_data(input ma_size_t size, input logic [31:0] sd);
        case (size)
            MA_BYTE: return {4{sd[7:0]}};
            MA_HALF: return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic is_misaligned(input ma_size_t size, input logic [1:0] a);
        return ((size == MA_HALF) && a[0]) || ((size == MA_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/stage_memory_load_align.sv
// Combinational load-data alignment: shifts the addressed byte/half down
// to bit 0 and sign- or zero-extends it. Usable on the instruction side too.
module load_align
    import stage_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  ma_size_t    size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    // Select the lane and extend it to 32 bits.
    always_comb begin
        shamt   = 5'd0;
        case (size)
            MA_BYTE: shamt = {offset, 3'b000};
            MA_HALF: shamt = {offset[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted = word >> shamt;
        case (size)
            MA_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            MA_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: issues data-memory loads/stores over a valid/ready
// request bus, aligns load data and hands results to writeback.
// Optional macro MEMORY_MISALIGN_TRAP_EN: misaligned HALF/WORD accesses
// skip the bus and complete with memory_misaligned_o=1, result = address.
//
// state | meaning
// IDLE  | accepting from execute; ALU ops complete here in one cycle
// REQ   | memory request presented, waiting for dmem_req_ready_i
// RSP   | load issued, waiting for response (watchdog running)
// OUT   | result held for writeback until memory_ready_i
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  control_word_t execute_cw_i,
    input  logic [31:0]   execute_result_i,
    input  logic [31:0]   execute_store_data_i,
    input  logic          execute_valid_i,
    output logic          execute_ready_o,
    output logic [31:0]   dmem_addr_o,
    output logic [31:0]   dmem_wr_data_o,
    output logic [3:0]    dmem_wr_mask_o,
    output logic          dmem_wr_en_o,
    output logic          dmem_req_valid_o,
    input  logic          dmem_req_ready_i,
    input  logic [31:0]   dmem_rsp_data_i,
    input  logic          dmem_rsp_valid_i,
    output control_word_t memory_cw_o,
    output logic [31:0]   memory_result_o,
    output logic          memory_misaligned_o,
    output logic          memory_fault_o,
    output logic          memory_valid_o,
    input  logic          memory_ready_i
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} memory_state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD =
        (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    memory_state_t state_q;
    control_word_t cw_q;
    logic [31:0]   addr_q;
    logic [31:0]   result_q;
    logic          valid_q, fault_q, misal_q;
    logic [31:0]   dmem_addr_q, dmem_wdata_q;
    logic [3:0]    dmem_mask_q;
    logic          dmem_wr_en_q, dmem_req_valid_q;
    logic [WD_W-1:0] wd_q;

    logic          execute_fire;
    logic          misaligned_in;
    logic          wd_expired;
    logic [31:0]   load_data;

`ifdef MEMORY_MISALIGN_TRAP_EN
    assign misaligned_in = is_misaligned(execute_cw_i.ma_size, execute_result_i[1:0]);
`else
    assign misaligned_in = 1'b0;
`endif

    assign execute_ready_o = (state_q == IDLE) && (!valid_q || memory_ready_i);
    assign execute_fire    = execute_valid_i && execute_ready_o;
    assign wd_expired      = (TIMEOUT_CYCLES > 0) && (wd_q == '0);

    load_align u_load_align (
        .word     (dmem_rsp_data_i),
        .offset   (addr_q[1:0]),
        .size     (cw_q.ma_size),
        .sign_ext (cw_q.ma_signed),
        .result   (load_data)
    );

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            cw_q             <= '0;
            addr_q           <= '0;
            result_q         <= '0;
            valid_q          <= 1'b0;
            fault_q          <= 1'b0;
            misal_q          <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            dmem_mask_q      <= '0;
            dmem_wr_en_q     <= 1'b0;
            dmem_req_valid_q <= 1'b0;
            wd_q             <= '0;
        end else begin
            wd_q <= '0;
            case (state_q)
                IDLE: begin
                    if (execute_fire) begin
                        cw_q    <= execute_cw_i;
                        addr_q  <= execute_result_i;
                        fault_q <= 1'b0;
                        misal_q <= 1'b0;
                        if (execute_cw_i.ma_mode == MA_NONE) begin
                            result_q <= execute_result_i;
                            valid_q  <= 1'b1;
                        end else if (misaligned_in) begin
                            result_q <= execute_result_i;
                            valid_q  <= 1'b1;
                            misal_q  <= 1'b1;
                            state_q  <= OUT;
                        end else begin
                            valid_q          <= 1'b0;
                            dmem_addr_q      <= {execute_result_i[31:2], 2'b00};
                            dmem_wdata_q     <= store_data(execute_cw_i.ma_size, execute_store_data_i);
                            dmem_mask_q      <= store_mask(execute_cw_i.ma_size, execute_result_i[1:0]);
                            dmem_wr_en_q     <= (execute_cw_i.ma_mode == MA_STORE);
                            dmem_req_valid_q <= 1'b1;
                            state_q          <= REQ;
                        end
                    end else if (memory_ready_i) begin
                        valid_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_req_ready_i) begin
                        dmem_req_valid_q <= 1'b0;
                        if (dmem_wr_en_q) begin
                            result_q <= addr_q;
                            valid_q  <= 1'b1;
                            state_q  <= OUT;
                        end else begin
                            wd_q    <= WD_LOAD;
                            state_q <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (dmem_rsp_valid_i) begin
                        result_q <= load_data;
                        valid_q  <= 1'b1;
                        state_q  <= OUT;
                    end else if (wd_expired) begin
                        result_q <= addr_q;
                        fault_q  <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= OUT;
                    end else begin
                        wd_q <= wd_q - WD_W'(1);
                    end
                end
                OUT: begin
                    if (memory_ready_i) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                        misal_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_addr_o         = dmem_addr_q;
    assign dmem_wr_data_o      = dmem_wdata_q;
    assign dmem_wr_mask_o      = dmem_mask_q;
    assign dmem_wr_en_o        = dmem_wr_en_q;
    assign dmem_req_valid_o    = dmem_req_valid_q;
    assign memory_cw_o         = cw_q;
    assign memory_result_o     = result_q;
    assign memory_valid_o      = valid_q;
    assign memory_fault_o      = fault_q;
    assign memory_misaligned_o = misal_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: vector table through a responsive memory
// model plus hand-written stall, watchdog, reset and misalignment sequences.
module tb_stage_memory;
    import stage_memory_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    control_word_t execute_cw_i = '0;
    logic [31:0]   execute_result_i = '0;
    logic [31:0]   execute_store_data_i = '0;
    logic          execute_valid_i = 1'b0;
    logic          execute_ready_o;
    logic [31:0]   dmem_addr_o, dmem_wr_data_o;
    logic [3:0]    dmem_wr_mask_o;
    logic          dmem_wr_en_o, dmem_req_valid_o;
    logic          dmem_req_ready_i = 1'b0;
    logic [31:0]   dmem_rsp_data_i = '0;
    logic          dmem_rsp_valid_i = 1'b0;
    control_word_t memory_cw_o;
    logic [31:0]   memory_result_o;
    logic          memory_misaligned_o, memory_fault_o, memory_valid_o;
    logic          memory_ready_i = 1'b1;

    int checks = 0;
    int errors = 0;

    stage_memory #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .execute_cw_i(execute_cw_i), .execute_result_i(execute_result_i),
        .execute_store_data_i(execute_store_data_i),
        .execute_valid_i(execute_valid_i), .execute_ready_o(execute_ready_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wr_data_o(dmem_wr_data_o),
        .dmem_wr_mask_o(dmem_wr_mask_o), .dmem_wr_en_o(dmem_wr_en_o),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_rsp_data_i(dmem_rsp_data_i), .dmem_rsp_valid_i(dmem_rsp_valid_i),
        .memory_cw_o(memory_cw_o), .memory_result_o(memory_result_o),
        .memory_misaligned_o(memory_misaligned_o), .memory_fault_o(memory_fault_o),
        .memory_valid_o(memory_valid_o), .memory_ready_i(memory_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        ma_mode_t    mode;
        ma_size_t    size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rsp;
        logic [31:0] exp_result;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic control_word_t mk_cw(input ma_mode_t m, input ma_size_t s, input logic sg);
        control_word_t cw;
        cw           = '0;
        cw.rd        = 5'd7;
        cw.wb_en     = 1'b1;
        cw.ma_mode   = m;
        cw.ma_size   = s;
        cw.ma_signed = sg;
        return cw;
    endfunction

    // Present one instruction and return at the negedge after it was accepted.
    task automatic transfer(input control_word_t cw, input logic [31:0] res, input logic [31:0] sd);
        int n;
        @(negedge clk_i);
        execute_cw_i         = cw;
        execute_result_i     = res;
        execute_store_data_i = sd;
        execute_valid_i      = 1'b1;
        n = 0;
        while (!execute_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("execute_ready_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        execute_valid_i = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!dmem_req_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!memory_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        control_word_t cw;
        cw = mk_cw(v.mode, v.size, v.sgn);
        memory_ready_i = 1'b1;
        transfer(cw, v.addr, v.sd);
        if (v.mode == MA_NONE) begin
            chk($sformatf("v%0d_alu_valid", idx), 32'(memory_valid_o), 32'd1);
            chk($sformatf("v%0d_alu_noreq", idx), 32'(dmem_req_valid_o), 32'd0);
        end else begin
            wait_req();
            chk($sformatf("v%0d_addr", idx), dmem_addr_o, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_wr_en", idx), 32'(dmem_wr_en_o), 32'(v.mode == MA_STORE));
            if (v.mode == MA_STORE) begin
                chk($sformatf("v%0d_wdata", idx), dmem_wr_data_o, v.exp_wdata);
                chk($sformatf("v%0d_mask", idx), 32'(dmem_wr_mask_o), 32'(v.exp_mask));
            end
            dmem_req_ready_i = 1'b1;
            @(negedge clk_i);
            dmem_req_ready_i = 1'b0;
            if (v.mode == MA_LOAD) begin
                dmem_rsp_data_i  = v.rsp;
                dmem_rsp_valid_i = 1'b1;
                @(negedge clk_i);
                dmem_rsp_valid_i = 1'b0;
            end
            wait_out();
            chk($sformatf("v%0d_fault", idx), 32'(memory_fault_o), 32'd0);
        end
        chk($sformatf("v%0d_result", idx), memory_result_o, v.exp_result);
        chk($sformatf("v%0d_cw", idx), 32'(memory_cw_o), 32'(cw));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] vals[3];
        vals = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333};

        vecs[0] = '{MA_NONE,  MA_WORD, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 4'h0};
        vecs[1] = '{MA_STORE, MA_WORD, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0, 32'h0000_0100, 32'h1122_3344, 4'b1111};
        vecs[2] = '{MA_STORE, MA_HALF, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 32'h0000_0102, 32'hBEEF_BEEF, 4'b1100};
        vecs[3] = '{MA_STORE, MA_BYTE, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0, 32'h0000_0101, 32'h7878_7878, 4'b0010};
        vecs[4] = '{MA_LOAD,  MA_BYTE, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_0102, 32'hFFFF_FF80, 32'h0, 4'h0};
        vecs[5] = '{MA_LOAD,  MA_BYTE, 1'b0, 32'h0000_0201, 32'h0, 32'h1234_56F0, 32'h0000_0056, 32'h0, 4'h0};
        vecs[6] = '{MA_LOAD,  MA_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 32'h0000_8001, 32'h0, 4'h0};
        vecs[7] = '{MA_LOAD,  MA_HALF, 1'b1, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF, 32'h0, 4'h0};
        vecs[8] = '{MA_LOAD,  MA_WORD, 1'b0, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'h0};
        vecs[9] = '{MA_LOAD,  MA_BYTE, 1'b1, 32'h0000_0200, 32'h0, 32'h0000_007F, 32'h0000_007F, 32'h0, 4'h0};

        // Reset state, with a stale response pulse that must be ignored.
        dmem_rsp_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_req_valid", 32'(dmem_req_valid_o), 32'd0);
        chk("rst_mem_valid", 32'(memory_valid_o), 32'd0);
        chk("rst_result", memory_result_o, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wdata", dmem_wr_data_o, 32'd0);
        chk("rst_mask", 32'(dmem_wr_mask_o), 32'd0);
        chk("rst_flags", {29'd0, dmem_wr_en_o, memory_fault_o, memory_misaligned_o}, 32'd0);
        chk("rst_cw", 32'(memory_cw_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        chk("stale_rsp_ignored", 32'(memory_valid_o), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-to-back ALU ops at one per cycle.
        memory_ready_i = 1'b1;
        @(negedge clk_i);
        execute_cw_i    = mk_cw(MA_NONE, MA_WORD, 1'b0);
        execute_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            execute_result_i = vals[i];
            @(negedge clk_i);
            chk($sformatf("b2b_result%0d", i), memory_result_o, vals[i]);
            chk($sformatf("b2b_ready%0d", i), 32'(execute_ready_o), 32'd1);
        end
        execute_valid_i = 1'b0;

        // Store byte with request stall of 3 cycles.
        transfer(mk_cw(MA_STORE, MA_BYTE, 1'b0), 32'h0000_1003, 32'hAABB_CCDD);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_req_valid%0d", i), 32'(dmem_req_valid_o), 32'd1);
            chk($sformatf("stall_addr%0d", i), dmem_addr_o, 32'h0000_1000);
            chk($sformatf("stall_wdata%0d", i), dmem_wr_data_o, 32'hDDDD_DDDD);
            chk($sformatf("stall_mask%0d", i), 32'(dmem_wr_mask_o), 32'b1000);
            chk($sformatf("stall_no_out%0d", i), 32'(memory_valid_o), 32'd0);
            if (i == 3) dmem_req_ready_i = 1'b1;
            @(negedge clk_i);
        end
        dmem_req_ready_i = 1'b0;
        chk("stall_store_valid", 32'(memory_valid_o), 32'd1);
        chk("stall_store_result", memory_result_o, 32'h0000_1003);
        chk("stall_store_req_drop", 32'(dmem_req_valid_o), 32'd0);

        // Signed half load, response after 5 cycles, output stalled 4 cycles.
        memory_ready_i = 1'b0;
        @(negedge clk_i);
        memory_ready_i = 1'b1;
        transfer(mk_cw(MA_LOAD, MA_HALF, 1'b1), 32'h0000_2002, 32'h0);
        memory_ready_i = 1'b0;
        chk("ldh_req_addr", dmem_addr_o, 32'h0000_2000);
        chk("ldh_req_valid", 32'(dmem_req_valid_o), 32'd1);
        dmem_req_ready_i = 1'b1;
        @(negedge clk_i);
        dmem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ldh_wait%0d", i), 32'(memory_valid_o), 32'd0);
            @(negedge clk_i);
        end
        dmem_rsp_data_i  = 32'h8001_7FFF;
        dmem_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        execute_cw_i     = mk_cw(MA_STORE, MA_WORD, 1'b0);
        execute_result_i = 32'h0000_55A0;
        execute_valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_valid%0d", i), 32'(memory_valid_o), 32'd1);
            chk($sformatf("hold_result%0d", i), memory_result_o, 32'hFFFF_8001);
            chk($sformatf("hold_exec_ready%0d", i), 32'(execute_ready_o), 32'd0);
            chk($sformatf("hold_no_req%0d", i), 32'(dmem_req_valid_o), 32'd0);
            @(negedge clk_i);
        end
        memory_ready_i = 1'b1;
        @(negedge clk_i);
        chk("hold_released", 32'(memory_valid_o), 32'd0);
        @(negedge clk_i);
        execute_valid_i = 1'b0;
        chk("after_hold_req", 32'(dmem_req_valid_o), 32'd1);
        chk("after_hold_addr", dmem_addr_o, 32'h0000_55A0);
        dmem_req_ready_i = 1'b1;
        @(negedge clk_i);
        dmem_req_ready_i = 1'b0;
        wait_out();
        chk("after_hold_store_result", memory_result_o, 32'h0000_55A0);

        // Watchdog: no response for 8 RSP cycles.
        transfer(mk_cw(MA_LOAD, MA_WORD, 1'b0), 32'h0000_4000, 32'h0);
        wait_req();
        dmem_req_ready_i = 1'b1;
        @(negedge clk_i);
        dmem_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wd_wait%0d", i), {31'd0, memory_valid_o}, 32'd0);
            @(negedge clk_i);
        end
        chk("wd_valid", 32'(memory_valid_o), 32'd1);
        chk("wd_fault", 32'(memory_fault_o), 32'd1);
        chk("wd_result", memory_result_o, 32'h0000_4000);
        dmem_rsp_data_i  = 32'h1234_5678;
        dmem_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        chk("late_rsp_no_valid", 32'(memory_valid_o), 32'd0);
        @(negedge clk_i);
        chk("late_rsp_no_valid2", 32'(memory_valid_o), 32'd0);
        chk("late_rsp_fault_clr", 32'(memory_fault_o), 32'd0);
        chk("late_rsp_idle", 32'(execute_ready_o), 32'd1);

        // Reset in the middle of a stalled request.
        transfer(mk_cw(MA_STORE, MA_WORD, 1'b0), 32'h0000_5000, 32'h0BAD_F00D);
        chk("mid_req_valid", 32'(dmem_req_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        dmem_rsp_valid_i = 1'b1;
        #1;
        chk("async_rst_req_drop", 32'(dmem_req_valid_o), 32'd0);
        chk("async_rst_mask", 32'(dmem_wr_mask_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        chk("post_rst_no_valid", 32'(memory_valid_o), 32'd0);
        chk("post_rst_no_req", 32'(dmem_req_valid_o), 32'd0);
        run_vec(10, vecs[0]);

`ifdef MEMORY_MISALIGN_TRAP_EN
        memory_ready_i = 1'b0;
        transfer(mk_cw(MA_LOAD, MA_WORD, 1'b0), 32'h0000_3001, 32'h0);
        chk("mis_no_req", 32'(dmem_req_valid_o), 32'd0);
        chk("mis_valid", 32'(memory_valid_o), 32'd1);
        chk("mis_flag", 32'(memory_misaligned_o), 32'd1);
        chk("mis_result", memory_result_o, 32'h0000_3001);
        memory_ready_i = 1'b1;
        transfer(mk_cw(MA_STORE, MA_HALF, 1'b0), 32'h0000_3003, 32'h1234);
        chk("mis_half_no_req", 32'(dmem_req_valid_o), 32'd0);
        chk("mis_half_flag", 32'(memory_misaligned_o), 32'd1);
        chk("mis_half_result", memory_result_o, 32'h0000_3003);
`else
        memory_ready_i = 1'b1;
        transfer(mk_cw(MA_LOAD, MA_WORD, 1'b0), 32'h0000_3001, 32'h0);
        wait_req();
        chk("unal_word_addr", dmem_addr_o, 32'h0000_3000);
        dmem_req_ready_i = 1'b1;
        @(negedge clk_i);
        dmem_req_ready_i = 1'b0;
        dmem_rsp_data_i  = 32'hCAFE_F00D;
        dmem_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        wait_out();
        chk("unal_word_result", memory_result_o, 32'hCAFE_F00D);
        chk("unal_word_flag", 32'(memory_misaligned_o), 32'd0);
`endif

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
